// File: rtl/bus_slot_scheduler_if.sv
// Bus-slot scheduler interface: the SPI handshake plus the per-slot bus timing
// outputs. clk16_i and reset_i are plain module ports and are not part of it.
//   master : the scheduler (drives every timing output, receives spi_valid_i)
//   slave  : the MCU/bus side (drives spi_valid_i, receives the timing)
interface bus_slot_scheduler_if;
    logic       spi_valid_i;   // MCU has an SPI transaction pending
    logic       spi_ready_o;   // one-cycle pulse: granted transaction complete
    logic       spi_en_o;      // SPI owns the bus this slot
    logic       vram_en_o;     // video RAM fetch slot
    logic       vrom_en_o;     // character ROM fetch slot
    logic       cpu_en_o;      // CPU access slot
    logic       cpu_be_o;      // CPU bus enable
    logic       cpu_clk_o;     // CPU PHI2
    logic       setup_o;       // address/control setup phase
    logic       strobe_o;      // data strobe window
    logic [1:0] slot_o;        // current slot index

    modport master (
        input  spi_valid_i,
        output spi_ready_o, spi_en_o, vram_en_o, vrom_en_o, cpu_en_o,
               cpu_be_o, cpu_clk_o, setup_o, strobe_o, slot_o
    );

    modport slave (
        output spi_valid_i,
        input  spi_ready_o, spi_en_o, vram_en_o, vrom_en_o, cpu_en_o,
               cpu_be_o, cpu_clk_o, setup_o, strobe_o, slot_o
    );
endinterface

// File: rtl/bus_slot_scheduler.sv
// Time-division scheduler for the shared system bus. Each 16-cycle CPU period
// is split into four 4-cycle slots (VRAM, VROM, SPI, CPU); every slot has a
// setup phase (p0), a strobe window (p1..p2) and a hold phase (p3).
// MCU SPI requests are granted whole slots through a valid/ready handshake.
// Ports:
//   clk16_i  - 16 MHz system clock
//   reset_i  - asynchronous, active-high reset
//   bus      - bus_slot_scheduler_if.master (handshake + slot timing outputs)
// Parameter:
//   VIDEO_EN - 1: slots 0/1 fetch video; 0: slots 0/1 are extra SPI slots
module bus_slot_scheduler #(
    parameter bit VIDEO_EN = 1'b1
) (
    input  logic                   clk16_i,
    input  logic                   reset_i,
    bus_slot_scheduler_if.master   bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SLOT_W = 2;
    localparam int unsigned PH_W   = 2;

    localparam logic [SLOT_W-1:0] SLOT_VRAM = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_VROM = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_SPI  = SLOT_W'(2);
    localparam logic [SLOT_W-1:0] SLOT_CPU  = SLOT_W'(3);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // run_q is clear only until the first edge after reset, so that edge
    // decodes cnt = 0 instead of cnt = 1.
    logic              run_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [SLOT_W-1:0] slot_d;
    logic [PH_W-1:0]   ph_d;
    logic              spi_slot_d;
    state_t            state_q;
    state_t            state_d;

    logic       spi_ready_d, spi_en_d, vram_en_d, vrom_en_d, cpu_d;
    logic       setup_d, strobe_d;

    logic       spi_ready_q, spi_en_q, vram_en_q, vrom_en_q, cpu_q;
    logic       setup_q, strobe_q;
    logic [SLOT_W-1:0] slot_q;

    // Next-count decode; every output register is loaded from it so outputs
    // line up with cnt without a cycle of latency.
    always_comb begin
        cnt_d      = run_q ? cnt_q + CNT_W'(1) : '0;
        slot_d     = cnt_d[CNT_W-1:PH_W];
        ph_d       = cnt_d[PH_W-1:0];
        spi_slot_d = (slot_d == SLOT_SPI) ||
                     (!VIDEO_EN && (slot_d != SLOT_CPU));
    end

    // SPI handshake next state and next output values.
    always_comb begin
        state_d     = state_q;
        spi_en_d    = 1'b0;
        spi_ready_d = 1'b0;
        vram_en_d   = 1'b0;
        vrom_en_d   = 1'b0;
        cpu_d       = 1'b0;
        setup_d     = 1'b0;
        strobe_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (spi_slot_d && (ph_d == PH_W'(0)) && bus.spi_valid_i)
                    state_d = S_BUSY;
            end
            S_BUSY: begin
                // Owns the slot through p3 regardless of spi_valid_i.
                if (ph_d == PH_W'(0))
                    state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // A request held high is never re-granted.
                if (!bus.spi_valid_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        spi_en_d    = (state_d == S_BUSY);
        spi_ready_d = (state_d == S_BUSY) && (ph_d == PH_W'(3));
        vram_en_d   = VIDEO_EN && (slot_d == SLOT_VRAM);
        vrom_en_d   = VIDEO_EN && (slot_d == SLOT_VROM);
        cpu_d       = (slot_d == SLOT_CPU);
        setup_d     = (ph_d == PH_W'(0));
        strobe_d    = (ph_d == PH_W'(1)) || (ph_d == PH_W'(2));
    end

    // Counter, FSM state and output registers.
    always_ff @(posedge clk16_i or posedge reset_i) begin
        if (reset_i) begin
            run_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            spi_ready_q <= 1'b0;
            spi_en_q    <= 1'b0;
            vram_en_q   <= 1'b0;
            vrom_en_q   <= 1'b0;
            cpu_q       <= 1'b0;
            setup_q     <= 1'b0;
            strobe_q    <= 1'b0;
            slot_q      <= '0;
        end else begin
            run_q       <= 1'b1;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            spi_ready_q <= spi_ready_d;
            spi_en_q    <= spi_en_d;
            vram_en_q   <= vram_en_d;
            vrom_en_q   <= vrom_en_d;
            cpu_q       <= cpu_d;
            setup_q     <= setup_d;
            strobe_q    <= strobe_d;
            slot_q      <= slot_d;
        end
    end

    assign bus.spi_ready_o = spi_ready_q;
    assign bus.spi_en_o    = spi_en_q;
    assign bus.vram_en_o   = vram_en_q;
    assign bus.vrom_en_o   = vrom_en_q;
    assign bus.cpu_en_o    = cpu_q;
    assign bus.cpu_be_o    = cpu_q;
    assign bus.cpu_clk_o   = cpu_q;
    assign bus.setup_o     = setup_q;
    assign bus.strobe_o    = strobe_q;
    assign bus.slot_o      = slot_q;

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// Directed bench for bus_slot_scheduler: one instance with video slots, one
// with slots 0/1 used for SPI. tcnt is the bench's own expected cnt.
module tb_bus_slot_scheduler;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   tcnt;
    int   ens;
    int   rdys;

    bus_slot_scheduler_if ifa ();
    bus_slot_scheduler_if ifb ();

    bus_slot_scheduler #(.VIDEO_EN(1'b1)) dut_a (
        .clk16_i (clk),
        .reset_i (rst),
        .bus     (ifa)
    );

    bus_slot_scheduler #(.VIDEO_EN(1'b0)) dut_b (
        .clk16_i (clk),
        .reset_i (rst),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cnt=%0d got=%0d want=%0d", tag, tcnt, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        tcnt = (tcnt + 1) % 16;
    endtask

    task automatic step_to(input int target);
        do step(); while (tcnt != target);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, int'({ifa.spi_ready_o, ifa.spi_en_o, ifa.vram_en_o, ifa.vrom_en_o,
                               ifa.cpu_en_o, ifa.cpu_be_o, ifa.cpu_clk_o, ifa.setup_o,
                               ifa.strobe_o, ifa.slot_o}), 0);
        chk({tag, "_b"}, int'({ifb.spi_ready_o, ifb.spi_en_o, ifb.vram_en_o, ifb.vrom_en_o,
                               ifb.cpu_en_o, ifb.cpu_be_o, ifb.cpu_clk_o, ifb.setup_o,
                               ifb.strobe_o, ifb.slot_o}), 0);
    endtask

    // Fixed slot/phase timing expected for cnt = tcnt.
    task automatic chk_timing(input string tag);
        int s;
        int p;
        s = tcnt / 4;
        p = tcnt % 4;
        chk({tag, "_slot"},   int'(ifa.slot_o), s);
        chk({tag, "_vram"},   int'(ifa.vram_en_o), (s == 0) ? 1 : 0);
        chk({tag, "_vrom"},   int'(ifa.vrom_en_o), (s == 1) ? 1 : 0);
        chk({tag, "_cpu"},    int'({ifa.cpu_en_o, ifa.cpu_be_o, ifa.cpu_clk_o}), (s == 3) ? 7 : 0);
        chk({tag, "_setup"},  int'(ifa.setup_o), (p == 0) ? 1 : 0);
        chk({tag, "_strobe"}, int'(ifa.strobe_o), (p == 1 || p == 2) ? 1 : 0);
        chk({tag, "_b_slot"}, int'(ifb.slot_o), s);
        chk({tag, "_b_vid"},  int'({ifb.vram_en_o, ifb.vrom_en_o}), 0);
        chk({tag, "_b_cpu"},  int'(ifb.cpu_en_o), (s == 3) ? 1 : 0);
    endtask

    // Video-less instance: raise at cnt raise_at, expect the grant in slot g,
    // drop valid right after the ready pulse, then expect a quiet bus.
    task automatic b_grant(input int raise_at, input int g);
        step_to(raise_at);
        ifb.spi_valid_i = 1'b1;
        do begin
            step();
            chk("b_en",  int'(ifb.spi_en_o), (tcnt / 4 == g) ? 1 : 0);
            chk("b_rdy", int'(ifb.spi_ready_o), (tcnt == 4 * g + 3) ? 1 : 0);
            chk("b_vid", int'({ifb.vram_en_o, ifb.vrom_en_o}), 0);
        end while (tcnt != 4 * g + 3);
        ifb.spi_valid_i = 1'b0;
        repeat (4) begin
            step();
            chk("b_post_en", int'({ifb.spi_en_o, ifb.spi_ready_o}), 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tcnt  = 15;
        rst   = 1'b1;
        ifa.spi_valid_i = 1'b0;
        ifb.spi_valid_i = 1'b0;

        // Reset state
        #12;
        chk_zero("reset");
        #10 rst = 1'b0;

        // Free-running timing, no SPI traffic
        for (int i = 0; i < 32; i++) begin
            step();
            chk_timing("idle");
            chk("idle_spi_a", int'({ifa.spi_en_o, ifa.spi_ready_o}), 0);
            chk("idle_spi_b", int'({ifb.spi_en_o, ifb.spi_ready_o}), 0);
        end

        // Request at cnt 3, dropped two cycles after ready
        step_to(3);
        ifa.spi_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("g1_en",  int'(ifa.spi_en_o), (tcnt >= 8 && tcnt <= 11) ? 1 : 0);
            chk("g1_rdy", int'(ifa.spi_ready_o), (tcnt == 11) ? 1 : 0);
            if (tcnt == 13) ifa.spi_valid_i = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            step();
            chk("g1_next", int'({ifa.spi_en_o, ifa.spi_ready_o}), 0);
        end

        // Request mid SPI slot waits for the next frame
        step_to(9);
        ifa.spi_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("g2_late", int'({ifa.spi_en_o, ifa.spi_ready_o}), 0);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            chk("g2_en",  int'(ifa.spi_en_o), (tcnt >= 8 && tcnt <= 11) ? 1 : 0);
            chk("g2_rdy", int'(ifa.spi_ready_o), (tcnt == 11) ? 1 : 0);
            if (tcnt == 13) ifa.spi_valid_i = 1'b0;
        end

        // Held request is granted once; drop/re-raise earns a second grant
        ifa.spi_valid_i = 1'b1;
        ens  = 0;
        rdys = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            ens  += int'(ifa.spi_en_o);
            rdys += int'(ifa.spi_ready_o);
            chk_timing("hold");
        end
        chk("hold_en_cycles", ens, 4);
        chk("hold_rdy_pulses", rdys, 1);
        step_to(2);
        ifa.spi_valid_i = 1'b0;
        step_to(5);
        ifa.spi_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("g3_en",  int'(ifa.spi_en_o), (tcnt >= 8 && tcnt <= 11) ? 1 : 0);
            chk("g3_rdy", int'(ifa.spi_ready_o), (tcnt == 11) ? 1 : 0);
        end
        ifa.spi_valid_i = 1'b0;

        // Video disabled: grants land in slots 0, 1 and 2
        b_grant(13, 0);
        b_grant(1, 1);
        b_grant(5, 2);

        // Reset in the middle of a granted slot
        step_to(6);
        ifa.spi_valid_i = 1'b1;
        step_to(9);
        chk("rst_busy_en", int'(ifa.spi_en_o), 1);
        #2 rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        ifa.spi_valid_i = 1'b0;
        #1 rst = 1'b0;
        tcnt = 15;
        for (int i = 0; i < 16; i++) begin
            step();
            chk_timing("rst_after");
            chk("rst_after_spi", int'({ifa.spi_en_o, ifa.spi_ready_o}), 0);
        end
        step_to(7);
        ifa.spi_valid_i = 1'b1;
        step();
        chk("rst_regrant_en", int'(ifa.spi_en_o), 1);
        step_to(11);
        chk("rst_regrant_rdy", int'(ifa.spi_ready_o), 1);
        ifa.spi_valid_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
